rr_req_enc: RTL and testbench

- Round-robin request encoder that sits directly upstream of the 2-to-4 decoder, `dec`.
- Arbitrates four request lines and drives the decoder's 2-bit select I and valid v, so the decoder's y is a one-hot grant.
- Holds each grant until it is acknowledged, the request is withdrawn, or a timeout expires.
- Guarantees a v=0 gap between grants, so y returns to 4'b0000 between owners.

---
 rtl/rr_req_enc.sv | 118 +++++++++++
 tb/tb_rr_req_enc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_req_enc.sv
// Round-robin request encoder driving a 2-to-4 decoder's select/valid pair.
// Grants are held until ack, withdrawal or timeout, with a one-cycle v=0 gap between owners.
module rr_req_enc #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] I,
  output logic       v,
  output logic       tmo
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  logic [0:0] state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] idx_reg, idx_next;
  logic       v_reg, v_next;
  logic       tmo_reg, tmo_next;

  // Candidate k is the (k+1)-th index after the last owner, so the
  // just-released requester is always examined last.
  logic [1:0] cand [4];
  logic [3:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = ptr_reg + 2'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  logic [1:0] win_idx;
  logic       any_req;

  always_comb begin
    win_idx = cand[3];
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) win_idx = cand[k];
    end
  end

  assign any_req = |req;

  logic rel_ack, rel_wd, rel_to, release_now;

  assign rel_ack     = ack;
  assign rel_wd      = ~req[idx_reg];
  assign rel_to      = TMO_EN && (cnt_reg == TMO_LAST);
  assign release_now = rel_ack | rel_wd | rel_to;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    v_next     = v_reg;
    tmo_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          idx_next   = win_idx;
          v_next     = 1'b1;
          cnt_next   = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          v_next     = 1'b0;
          ptr_next   = idx_reg;
          cnt_next   = 8'd0;
          state_next = IDLE;
          // A simultaneous ack or withdrawal takes precedence over timeout.
          tmo_next   = rel_to & ~rel_ack & ~rel_wd;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        v_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'b11;
      cnt_reg   <= 8'd0;
      idx_reg   <= 2'b00;
      v_reg     <= 1'b0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      v_reg     <= v_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign I   = idx_reg;
  assign v   = v_reg;
  assign tmo = tmo_reg;

endmodule

// File: tb/tb_rr_req_enc.sv
// Bench for rr_req_enc: directed plan steps plus random traffic, two instances
// (TIMEOUT=8 and TIMEOUT=0) checked against a grant-level reference model.
module tb_rr_req_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] i8, i0;
  logic       v8, v0, t8, t0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_step = 0;

  always #5 clk = ~clk;

  rr_req_enc #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .I(i8), .v(v8), .tmo(t8)
  );

  rr_req_enc #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .I(i0), .v(v0), .tmo(t0)
  );

  // Reference model: per instance, whether a grant is live, who owns it,
  // how many cycles it has been visible, and who owned the previous one.
  int m_limit [2] = '{8, 0};
  bit m_busy  [2];
  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  bit m_tmo   [2];

  task automatic model_edge(input int d);
    bit by_ack, by_wd, by_to;
    if (rst) begin
      m_busy[d] = 0; m_owner[d] = 0; m_last[d] = 3; m_held[d] = 0; m_tmo[d] = 0;
    end else if (!m_busy[d]) begin
      m_tmo[d] = 0;
      if (req != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          if (!m_busy[d] && req[(m_last[d] + k) % 4]) begin
            m_owner[d] = (m_last[d] + k) % 4;
            m_busy[d]  = 1;
            m_held[d]  = 1;
          end
        end
      end
    end else begin
      by_ack = ack;
      by_wd  = !req[m_owner[d]];
      by_to  = (m_limit[d] != 0) && (m_held[d] == m_limit[d]);
      if (by_ack || by_wd || by_to) begin
        m_busy[d] = 0;
        m_last[d] = m_owner[d];
        m_tmo[d]  = by_to && !by_ack && !by_wd;
      end else begin
        m_tmo[d]  = 0;
        m_held[d] = m_held[d] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
  endtask

  // One clock transaction: inputs are already applied, advance one edge,
  // then compare both instances against the model.
  task automatic step(input logic r, input logic [3:0] q, input logic a);
    rst = r; req = q; ack = a;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    n_step++;
    $display("step %0d rst=%0b req=%b ack=%0b | T8 I=%0d v=%0b tmo=%0b | T0 I=%0d v=%0b tmo=%0b",
             n_step, r, q, a, i8, v8, t8, i0, v0, t0);
    check("t8_v",   {7'b0, v8}, {7'b0, m_busy[0]});
    check("t8_I",   {6'b0, i8}, 8'(m_owner[0]));
    check("t8_tmo", {7'b0, t8}, {7'b0, m_tmo[0]});
    check("t0_v",   {7'b0, v0}, {7'b0, m_busy[1]});
    check("t0_I",   {6'b0, i0}, 8'(m_owner[1]));
    check("t0_tmo", {7'b0, t0}, {7'b0, m_tmo[1]});
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; ack = 1'b0;

    // Reset with all requests pending, then four-way rotation with ack on cycle 3.
    step(1, 4'hF, 0);
    step(1, 4'hF, 0);
    check("rst_v", {7'b0, v8}, 8'd0);
    check("rst_I", {6'b0, i8}, 8'd0);
    for (int g = 0; g < 5; g++) begin
      step(0, 4'hF, 0);
      check("rot_I", {6'b0, i8}, 8'(g % 4));
      step(0, 4'hF, 0);
      step(0, 4'hF, 0);
      step(0, 4'hF, 1);
      check("rot_gap_v", {7'b0, v8}, 8'd0);
    end

    // Sparse fairness between requesters 0 and 2.
    step(1, 4'h0, 0);
    for (int g = 0; g < 4; g++) begin
      step(0, 4'h5, 0);
      check("sparse_I", {6'b0, i8}, 8'((g % 2) * 2));
      step(0, 4'h5, 0);
      step(0, 4'h5, 1);
    end

    // Timeout: requester 1 holds for exactly 8 cycles, then 2 is granted.
    step(1, 4'h0, 0);
    step(0, 4'h6, 0);
    check("to_I", {6'b0, i8}, 8'd1);
    for (int c = 0; c < 7; c++) step(0, 4'h6, 0);
    check("to_v_last", {7'b0, v8}, 8'd1);
    step(0, 4'h6, 0);
    check("to_tmo", {7'b0, t8}, 8'd1);
    check("to_gap_v", {7'b0, v8}, 8'd0);
    check("no_to_v", {7'b0, v0}, 8'd1);
    step(0, 4'h6, 0);
    check("to_next_I", {6'b0, i8}, 8'd2);
    check("to_tmo_clr", {7'b0, t8}, 8'd0);

    // Withdrawal release, then ack colliding with timeout expiry.
    step(1, 4'h0, 0);
    step(0, 4'h8, 0);
    check("wd_I", {6'b0, i8}, 8'd3);
    step(0, 4'h8, 0);
    step(0, 4'h0, 0);
    check("wd_v", {7'b0, v8}, 8'd0);
    step(0, 4'h1, 0);
    for (int c = 0; c < 7; c++) step(0, 4'h1, 0);
    step(0, 4'h1, 1);
    check("coll_v", {7'b0, v8}, 8'd0);
    check("coll_tmo", {7'b0, t8}, 8'd0);

    // Reset in the middle of a grant.
    step(1, 4'h0, 0);
    step(0, 4'h4, 0);
    step(0, 4'h4, 0);
    step(1, 4'h4, 0);
    check("midrst_v", {7'b0, v8}, 8'd0);
    check("midrst_I", {6'b0, i8}, 8'd0);
    step(0, 4'h5, 0);
    check("midrst_I2", {6'b0, i8}, 8'd0);

    // Random traffic: mostly-stable requests, sparse acks, rare resets.
    begin
      logic [3:0] rq;
      rq = 4'hF;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
        step(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 5) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
